// File: rtl/dac_glitch_sched.sv
// Glitch DAC sequencer.
// Arbitrates main/priv trigger requests and runs one timed glitch per grant:
// delay, glitch-level pulse, restore to nominal, holdoff.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | track nominal_level onto the DAC, arbitrate new requests
// S_DELAY   | grant cycle plus D further cycles before the glitch edge
// S_GLITCH  | glitch code on dac_level for W cycles
// S_RESTORE | single cycle, nominal code reloaded, done pulses
// S_HOLDOFF | H dead cycles, requests ignored
module dac_glitch_sched #(
    parameter int               DAC_W       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [DAC_W-1:0] RESET_LEVEL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             main_req,
    input  logic [DAC_W-1:0] main_level,
    input  logic             priv_req,
    input  logic [DAC_W-1:0] priv_level,
    input  logic [DAC_W-1:0] nominal_level,
    input  logic [CNT_W-1:0] delay_cyc,
    input  logic [CNT_W-1:0] width_cyc,
    input  logic [CNT_W-1:0] holdoff_cyc,
    output logic             main_gnt,
    output logic             priv_gnt,
    output logic             busy,
    output logic             done,
    output logic [DAC_W-1:0] dac_level,
    output logic             dac_clk
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_GLITCH,
        S_RESTORE,
        S_HOLDOFF
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] w_m1_q, h_q, w_m1;
    logic [DAC_W-1:0] glitch_q, nom_q;
    logic             rr_last_priv;
    logic             ld_q;
    logic             grant, win_priv;
    logic             trk_load, glitch_load, restore_load;

    // Glitch width is held at two or more cycles so the two strobes never touch.
    assign w_m1 = (width_cyc < CNT_W'(2)) ? CNT_W'(1) : width_cyc - 1'b1;
    assign busy = (state != S_IDLE);

    // State and counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, counter reload and DAC load selection.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        grant        = 1'b0;
        win_priv     = 1'b0;
        trk_load     = 1'b0;
        glitch_load  = 1'b0;
        restore_load = 1'b0;
        unique case (state)
            S_IDLE: begin
                // A load whose strobe has not yet gone out blocks both a
                // second tracking load and a grant.
                if (dac_level != nominal_level && !dac_clk && !ld_q) begin
                    trk_load = 1'b1;
                end else if (arm && (main_req || priv_req) && !ld_q &&
                             dac_level == nominal_level) begin
                    grant     = 1'b1;
                    win_priv  = priv_req && (!main_req || !rr_last_priv);
                    state_nxt = S_DELAY;
                    cnt_nxt   = delay_cyc;
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    state_nxt   = S_GLITCH;
                    cnt_nxt     = w_m1_q;
                    glitch_load = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_GLITCH: begin
                if (cnt == '0) begin
                    state_nxt    = S_RESTORE;
                    restore_load = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_RESTORE: begin
                if (h_q == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_HOLDOFF;
                    cnt_nxt   = h_q - 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant-time capture of the sequence parameters and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q     <= '0;
            nom_q        <= '0;
            w_m1_q       <= '0;
            h_q          <= '0;
            rr_last_priv <= 1'b1;
        end else if (grant) begin
            glitch_q     <= win_priv ? priv_level : main_level;
            nom_q        <= nominal_level;
            w_m1_q       <= w_m1;
            h_q          <= holdoff_cyc;
            rr_last_priv <= win_priv;
        end
    end

    // Registered outputs; every DAC load is followed one cycle later by a strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dac_level <= RESET_LEVEL;
            ld_q      <= 1'b0;
            dac_clk   <= 1'b0;
            main_gnt  <= 1'b0;
            priv_gnt  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (trk_load) begin
                dac_level <= nominal_level;
            end else if (glitch_load) begin
                dac_level <= glitch_q;
            end else if (restore_load) begin
                dac_level <= nom_q;
            end
            ld_q     <= trk_load || glitch_load || restore_load;
            dac_clk  <= ld_q;
            main_gnt <= grant && !win_priv;
            priv_gnt <= grant && win_priv;
            done     <= restore_load;
        end
    end

endmodule
